// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ valid/ready requesters into one
// registered output word tagged with the ID of the requester that supplied it.
module rr_reg_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic                          o_valid,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic [ID_W-1:0]               o_id,
    input  logic                          i_ready,
    output logic                          o_busy
);

    typedef enum logic {
        EMPTY,
        FULL
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] winner;
    logic            found;
    logic            can_load;
    logic            transfer;

    // Search begins just past the last winner, so a freshly served requester
    // drops to lowest priority.
    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(last_grant) + off) % NUM_REQ;
            if (!found && i_req_valid[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    assign can_load = (state == EMPTY) || i_ready;
    assign transfer = i_reset_n && can_load && found;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (transfer) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (transfer) begin
                    state_next = FULL;
                end else if (i_ready) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_comb begin
        o_valid     = (state == FULL);
        o_req_ready = '0;
        if (transfer) begin
            o_req_ready[winner] = 1'b1;
        end
        o_busy = o_valid || (|i_req_valid);
    end

    // Priority only rotates on an actual transfer; idle cycles leave it alone.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_data     <= '0;
            o_id       <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
        end else if (transfer) begin
            o_data     <= i_req_data[winner*DATA_WIDTH +: DATA_WIDTH];
            o_id       <= winner;
            last_grant <= winner;
        end
    end

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Table-driven bench for rr_reg_arbiter: each vector is one clock cycle of
// stimulus plus the required grant; accepted words are tracked in a scoreboard.
module tb_rr_reg_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [IW-1:0]     out_id;
    logic              out_ready;
    logic              busy;

    rr_reg_arbiter #(
        .DATA_WIDTH(DW),
        .NUM_REQ   (NR)
    ) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_req_valid(req_valid),
        .i_req_data (req_data),
        .o_req_ready(req_ready),
        .o_valid    (out_valid),
        .o_data     (out_data),
        .o_id       (out_id),
        .i_ready    (out_ready),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             rst_n;
        logic [NR-1:0]    valid;
        logic [NR*DW-1:0] data;
        logic             ready;
        logic [NR-1:0]    exp_ready;
    } vec_t;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } word_t;

    vec_t  vecs[$];
    word_t sb[$];
    int    checks = 0;
    int    passes = 0;

    logic          exp_full;
    logic [IW-1:0] cur_id;
    logic [DW-1:0] cur_data;
    logic          pend;
    int            wait_cnt[NR];
    vec_t          prev_v;
    logic          have_prev;

    task automatic addVec(input logic r, input logic [NR-1:0] v, input logic [NR*DW-1:0] d,
                          input logic rd, input logic [NR-1:0] er);
        vec_t e;
        e.rst_n     = r;
        e.valid     = v;
        e.data      = d;
        e.ready     = rd;
        e.exp_ready = er;
        vecs.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one cycle of stimulus and flags any requester that drops or
    // changes an offer before it was accepted.
    task automatic applyStimulus(input vec_t v);
        if (have_prev && prev_v.rst_n && v.rst_n) begin
            for (int r = 0; r < NR; r++) begin
                if (prev_v.valid[r] && !prev_v.exp_ready[r] &&
                    (!v.valid[r] || v.data[r*DW +: DW] != prev_v.data[r*DW +: DW])) begin
                    checks++;
                    $display("[TB] FAIL stimulus_rule r%0d: offer withdrawn, required held", r);
                end
            end
        end
        rst_n     = v.rst_n;
        req_valid = v.valid;
        req_data  = v.data;
        out_ready = v.ready;
        prev_v    = v;
        have_prev = 1'b1;
    endtask

    // Compares the DUT against the vector and the scoreboard, then advances
    // the expected output-register state across the coming clock edge.
    task automatic checkOutput(input int n, input vec_t v);
        word_t w;
        int    gi;
        if (pend) begin
            w        = sb.pop_front();
            cur_id   = w.id;
            cur_data = w.data;
            pend     = 1'b0;
        end
        check($sformatf("c%0d o_req_ready", n), 32'(req_ready), 32'(v.exp_ready));
        check($sformatf("c%0d o_valid", n), 32'(out_valid), 32'(exp_full));
        check($sformatf("c%0d o_data", n), 32'(out_data), 32'(cur_data));
        check($sformatf("c%0d o_id", n), 32'(out_id), 32'(cur_id));
        check($sformatf("c%0d o_busy", n), 32'(busy), 32'(exp_full | (|v.valid)));

        for (int r = 0; r < NR; r++) begin
            if (!v.rst_n || !v.valid[r]) begin
                wait_cnt[r] = 0;
            end else if (req_ready[r]) begin
                check($sformatf("c%0d starve_r%0d", n, r), 32'(wait_cnt[r] <= NR - 1), 32'd1);
                wait_cnt[r] = 0;
            end else if (|req_ready) begin
                wait_cnt[r]++;
            end
        end

        if (!v.rst_n) begin
            exp_full = 1'b0;
            cur_id   = '0;
            cur_data = '0;
            pend     = 1'b0;
            sb.delete();
        end else if (v.exp_ready != '0) begin
            gi = 0;
            for (int r = 0; r < NR; r++) begin
                if (v.exp_ready[r]) gi = r;
            end
            w.id   = IW'(gi);
            w.data = v.data[gi*DW +: DW];
            sb.push_back(w);
            pend     = 1'b1;
            exp_full = 1'b1;
        end else if (exp_full && v.ready) begin
            exp_full = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] d0, d1, d2, d3;
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;
        exp_full  = 1'b0;
        cur_id    = '0;
        cur_data  = '0;
        pend      = 1'b0;
        have_prev = 1'b0;
        for (int r = 0; r < NR; r++) wait_cnt[r] = 0;

        d0 = 32'h1312_1110;
        d1 = 32'h1312_11A5;
        d2 = 32'h133C_11A5;
        d3 = 32'h773C_11A5;

        // Reset held with every requester asserting
        for (int k = 0; k < 3; k++) addVec(1'b0, 4'hF, d0, 1'b1, 4'h0);
        // Rotation 0,1,2,3 twice; served requesters then drop out
        addVec(1'b1, 4'hF, d0, 1'b1, 4'h1);
        addVec(1'b1, 4'hF, d0, 1'b1, 4'h2);
        addVec(1'b1, 4'hF, d0, 1'b1, 4'h4);
        addVec(1'b1, 4'hF, d0, 1'b1, 4'h8);
        addVec(1'b1, 4'hF, d0, 1'b1, 4'h1);
        addVec(1'b1, 4'hE, d0, 1'b1, 4'h2);
        addVec(1'b1, 4'hC, d0, 1'b1, 4'h4);
        addVec(1'b1, 4'h8, d0, 1'b1, 4'h8);
        // Wrap-around: after 3, requester 0 beats 2; after 1, requester 2 beats 0
        addVec(1'b1, 4'h5, d0, 1'b1, 4'h1);
        addVec(1'b1, 4'h4, d0, 1'b1, 4'h4);
        addVec(1'b1, 4'h2, d0, 1'b1, 4'h2);
        addVec(1'b1, 4'h5, d0, 1'b1, 4'h4);
        addVec(1'b1, 4'h1, d0, 1'b1, 4'h1);
        // Back-pressure: 0xA5 held for five stalled cycles, requester 1 waiting
        addVec(1'b1, 4'h1, d1, 1'b1, 4'h1);
        for (int k = 0; k < 5; k++) addVec(1'b1, 4'h2, d1, 1'b0, 4'h0);
        addVec(1'b1, 4'h2, d1, 1'b1, 4'h2);
        addVec(1'b1, 4'h0, d1, 1'b1, 4'h0);
        // Drain to empty with a lone 0x3C word
        addVec(1'b1, 4'h4, d2, 1'b1, 4'h4);
        addVec(1'b1, 4'h0, d2, 1'b1, 4'h0);
        addVec(1'b1, 4'h0, d2, 1'b1, 4'h0);
        // Reset while holding 0x77 with requests pending
        addVec(1'b1, 4'h8, d3, 1'b0, 4'h8);
        addVec(1'b1, 4'h3, d3, 1'b0, 4'h0);
        addVec(1'b0, 4'h3, d3, 1'b0, 4'h0);
        addVec(1'b1, 4'h3, d3, 1'b0, 4'h1);
        addVec(1'b1, 4'h2, d3, 1'b1, 4'h2);
        addVec(1'b1, 4'h0, d3, 1'b1, 4'h0);
        addVec(1'b1, 4'h0, d3, 1'b1, 4'h0);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput(i, vecs[i]);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rr_reg_arbiter.md
# rr_reg_arbiter

Round-robin arbiter that shares one pipeline data register between NUM_REQ requesters. Each requester offers a DATA_WIDTH word with a valid/ready handshake. One winner per cycle is captured into a single output register, which presents the word downstream with its source ID under a valid/ready handshake. The block sits in front of the sandbox datapath register and lets several producers feed it without collisions or starvation.

## Interface
- DATA_WIDTH, 8, width of each data word
- NUM_REQ, 4, number of requesters (2..16)
- ID_W, $clog2(NUM_REQ), width of the source ID (derived; not overridden)

- i_clk  input  1  clock; all logic on its rising edge
- i_reset_n  input  1  reset, synchronous, active-low
- i_req_valid  input  NUM_REQ  bit r: requester r offers a word
- i_req_data  input  NUM_REQ*DATA_WIDTH  word r in bits [r*DATA_WIDTH +: DATA_WIDTH]
- o_req_ready  output  NUM_REQ  one-hot or zero: word r is accepted this cycle
- o_valid  output  1  output register holds a word
- o_data  output  DATA_WIDTH  held word
- o_id  output  ID_W  index of the requester that supplied o_data
- i_ready  input  1  downstream accepts o_data this cycle
- o_busy  output  1  o_valid OR any i_req_valid bit set

## Operation
- State machine with two states:
  - EMPTY: output register empty.
  - FULL: output register holds a word; o_valid = 1.
- can_load = (state == EMPTY) OR i_ready.
- Arbitration is combinational each cycle:
  - Search starts at index (last_grant + 1) mod NUM_REQ and moves upward with wrap-around.
  - The first set i_req_valid bit wins.
- o_req_ready[w] = can_load AND a winner w exists. All other bits are 0. o_req_ready depends combinationally on i_ready and i_req_valid.
- On a transfer (o_req_ready[w] = 1):
  - At the next edge, o_data <= word w, o_id <= w, last_grant <= w, state <= FULL.
- EMPTY with no winner: stay EMPTY.
- FULL with i_ready and no winner: go to EMPTY. o_data and o_id keep their last values.
- FULL with i_ready low: hold. o_data and o_id stay stable and no ready is issued.
- FULL with i_ready and a winner: drain and load in the same cycle, so state stays FULL with the new word.
- last_grant changes only on a transfer. Idle cycles do not rotate priority.
- Requester rules:
  - Once i_req_valid[r] is raised, it stays high and i_req_data stable until o_req_ready[r].
  - A requester with valid held continuously is served within NUM_REQ transfers.
  - The bench flags any violation of these rules; the RTL does not check them.
- Reset (i_reset_n low at an edge, including mid-transfer):
  - state <= EMPTY, o_valid = 0, o_data = 0, o_id = 0, last_grant = NUM_REQ-1 (so requester 0 has first priority).
  - An in-flight word is dropped.
  - While reset is low, o_req_ready = 0 regardless of inputs.

## Timing
- Latency: one cycle from the accepting edge to o_valid/o_data at the output.
- Throughput: one word per cycle while i_ready stays high and any request is pending.
- Output back-pressure reaches the requesters in the same cycle via can_load. No skid buffer.
- o_valid, o_data and o_id are registered. o_req_ready and o_busy are combinational.
- After reset deasserts, the first transfer can be accepted in that same cycle.

## Test plan
- Reset check: hold i_reset_n=0 for 3 cycles with all requests high. Required: o_valid=0, o_data=0, o_id=0, o_req_ready=0. First grant after release goes to requester 0.
- Round-robin fairness:
  - Stimulus: NUM_REQ=4, all valid, each data = 0x10+r, i_ready=1.
  - Required: o_id sequence 0,1,2,3,0,1… and o_data sequence 0x10,0x11,0x12,0x13,…, one word per cycle.
- Wrap-around:
  - Stimulus: grant requester 3 alone, then raise requesters 0 and 2 together.
  - Required: 0 granted before 2.
  - Stimulus: then grant requester 1 alone, then raise 0 and 2 together.
  - Required: 2 granted before 0.
- Back-pressure:
  - Stimulus: o_valid=1 with data 0xA5, i_ready=0 for 5 cycles, requester 1 pending.
  - Required: o_data stays 0xA5, o_req_ready=0 throughout. The cycle i_ready rises, o_req_ready[1]=1, and next cycle o_id=1.
- Drain to empty: single word 0x3C accepted with no further requests and i_ready=1. Required: o_valid=1 for exactly one cycle, then EMPTY, then o_busy=0.
- Reset mid-operation: assert reset while FULL (o_data=0x77) with requests pending. Required: next cycle o_valid=0, o_data=0, and the 0x77 word is never seen downstream.
